pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 64: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter NOP_VALUE, default all-zero WIDTH bits: payload loaded on reset and flush.
REQ-003 SHALL have parameter CNT_W, default 16: event counter width, legal range 2..32.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream payload is a real instruction/bundle.
REQ-007 SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-008 SHALL have port stall, input, 1 bit: hold the stage contents.
REQ-009 SHALL have port flush, input, 1 bit: squash the stage contents.
REQ-010 SHALL have port in_ready, output, 1 bit: the stage accepts in_data this cycle.
REQ-011 SHALL have port out_valid, output, 1 bit: registered valid.
REQ-012 SHALL have port out_data, output, WIDTH bits: registered payload.
REQ-013 SHALL have port flush_pending, output, 1 bit: a flush is deferred behind a stall.
REQ-014 SHALL have port stall_cnt, output, CNT_W bits: count of stalled cycles.
REQ-015 SHALL have port flush_cnt, output, CNT_W bits: count of applied flushes.

Function
REQ-016 SHALL drive in_ready = !stall combinationally.
REQ-017 SHALL implement a two-state FSM: RUN and PEND.
REQ-018 In RUN, on stall=1 and flush=0, SHALL hold out_valid and out_data and stay in RUN.
REQ-019 In RUN, on stall=1 and flush=1, SHALL hold out_valid and out_data and move to PEND.
REQ-020 In RUN, on stall=0 and flush=1, SHALL load out_data=NOP_VALUE and out_valid=0, and stay in RUN.
REQ-021 In RUN, on stall=0 and flush=0, SHALL load out_data=in_data and out_valid=in_valid, with 1-cycle latency.
REQ-022 In PEND, on stall=1, SHALL hold out_valid and out_data and stay in PEND, regardless of flush.
REQ-023 In PEND, on stall=0, SHALL load NOP_VALUE with out_valid=0 and return to RUN, regardless of flush or in_data; the deferred flush and any coincident flush SHALL count as one applied flush.
REQ-024 SHALL drive flush_pending=1 exactly while in PEND (registered).
REQ-025 SHALL increment stall_cnt by 1 on each rising edge where stall=1, saturating at 2^CNT_W-1 with no wrap.
REQ-026 SHALL increment flush_cnt by 1 on each edge where a NOP load occurs due to a flush (REQ-020, REQ-023), saturating at 2^CNT_W-1 with no wrap.
REQ-027 SHALL treat in_valid=0 with stall=0 and flush=0 as a bubble: load in_data and set out_valid=0, with no counter change.
REQ-028 SHALL never lose a flush: every flush asserted while stalled SHALL take effect on the first non-stalled edge.

Reset
REQ-029 On reset=1, SHALL immediately, without waiting for clk, set out_data=NOP_VALUE, out_valid=0, FSM=RUN, flush_pending=0, stall_cnt=0, flush_cnt=0.
REQ-030 Reset asserted in PEND SHALL discard the deferred flush without counting it.
REQ-031 After reset deassertion, the first rising edge SHALL behave per RUN rules.

Verification
REQ-032 Load: WIDTH=64, in_valid=1, in_data=0x0000_0000_DEAD_BEEF, stall=0, flush=0, one edge -> out_valid=1, out_data=0x...DEADBEEF, counters=0.
REQ-033 Stall hold: after REQ-032, stall=1 for 3 edges with in_data changing -> out_data unchanged, in_ready=0, stall_cnt=3.
REQ-034 Deferred flush: stall=1 with flush=1 for 1 edge -> flush_pending=1 and out_data held; then stall=0, flush=0, in_data=0x1234 -> out_valid=0, out_data=NOP_VALUE, flush_pending=0, flush_cnt=1.
REQ-035 Direct flush: stall=0, flush=1, in_valid=1 -> out_valid=0, out_data=NOP_VALUE, flush_cnt increments by 1; the next edge with flush=0 loads in_data normally.
REQ-036 Saturation: CNT_W=2, stall=1 for 6 edges -> stall_cnt sequence 1,2,3,3,3,3.
REQ-037 Async reset mid-PEND: enter PEND with stall_cnt=5, assert reset between edges -> all outputs reset immediately; after release, stall=0 -> no flush counted, flush_cnt=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: 1-cycle latency with hold on stall and squash-to-NOP on flush.
// Backpressure: in_ready = !stall; a flush seen while stalled is deferred until the stall drops.
module pipe_stage_reg #(
    parameter int                 WIDTH     = 64,
    parameter logic [WIDTH-1:0]   NOP_VALUE = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             flush_pending,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, PEND} state_t;

    state_t state;
    state_t state_nxt;
    logic   load_data;
    logic   load_nop;

    assign in_ready      = !stall;
    assign flush_pending = (state == PEND);

    always_comb begin
        state_nxt = state;
        load_data = 1'b0;
        load_nop  = 1'b0;
        unique case (state)
            RUN: begin
                if (stall) begin
                    if (flush) state_nxt = PEND;
                end else if (flush) begin
                    load_nop = 1'b1;
                end else begin
                    load_data = 1'b1;
                end
            end
            PEND: begin
                // Deferred and coincident flush collapse into a single NOP load.
                if (!stall) begin
                    load_nop  = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            out_valid <= 1'b0;
            out_data  <= NOP_VALUE;
        end else begin
            state <= state_nxt;
            if (load_nop) begin
                out_valid <= 1'b0;
                out_data  <= NOP_VALUE;
            end else if (load_data) begin
                out_valid <= in_valid;
                out_data  <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (load_nop && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a 64-bit stage with a non-zero NOP, plus an 8-bit CNT_W=2 stage for saturation.
module tb_pipe_stage_reg;

    localparam logic [63:0] NOP = 64'h0BAD_F00D_0000_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        stall;
    logic        flush;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        flush_pending;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        s_stall;
    logic        s_flush;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_data;
    logic        s_flush_pending;
    logic [1:0]  s_stall_cnt;
    logic [1:0]  s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(64), .NOP_VALUE(NOP), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .stall(stall), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .flush_pending(flush_pending),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.WIDTH(8), .NOP_VALUE(8'h00), .CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data[7:0]),
        .stall(s_stall), .flush(s_flush), .in_ready(s_in_ready), .out_valid(s_out_valid),
        .out_data(s_out_data), .flush_pending(s_flush_pending),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0;
        s_stall = 1'b0; s_flush = 1'b0;
        repeat (2) step();
        check("rst_valid",   64'(out_valid), 64'd0);
        check("rst_data",    out_data, NOP);
        check("rst_pend",    64'(flush_pending), 64'd0);
        check("rst_scnt",    64'(stall_cnt), 64'd0);
        check("rst_fcnt",    64'(flush_cnt), 64'd0);
        check("rst_ready",   64'(in_ready), 64'd1);
        reset = 1'b0;

        // Plain load
        in_valid = 1'b1; in_data = 64'h0000_0000_DEAD_BEEF;
        step();
        check("load_valid",  64'(out_valid), 64'd1);
        check("load_data",   out_data, 64'h0000_0000_DEAD_BEEF);
        check("load_scnt",   64'(stall_cnt), 64'd0);
        check("load_fcnt",   64'(flush_cnt), 64'd0);

        // Stall hold with changing input
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 64'h1111_1111_1111_1111 * 64'(i);
            step();
        end
        check("hold_data",   out_data, 64'h0000_0000_DEAD_BEEF);
        check("hold_valid",  64'(out_valid), 64'd1);
        check("hold_ready",  64'(in_ready), 64'd0);
        check("hold_scnt",   64'(stall_cnt), 64'd3);

        // Deferred flush
        flush = 1'b1;
        step();
        check("defer_pend",  64'(flush_pending), 64'd1);
        check("defer_data",  out_data, 64'h0000_0000_DEAD_BEEF);
        check("defer_fcnt",  64'(flush_cnt), 64'd0);
        stall = 1'b0; flush = 1'b0; in_data = 64'h1234;
        step();
        check("apply_valid", 64'(out_valid), 64'd0);
        check("apply_data",  out_data, NOP);
        check("apply_pend",  64'(flush_pending), 64'd0);
        check("apply_fcnt",  64'(flush_cnt), 64'd1);
        check("apply_scnt",  64'(stall_cnt), 64'd4);

        // Several flushes under one stall plus a coincident one count once
        stall = 1'b1; flush = 1'b1; in_data = 64'h9999;
        repeat (2) step();
        flush = 1'b0;
        step();
        check("multi_pend",  64'(flush_pending), 64'd1);
        stall = 1'b0; flush = 1'b1;
        step();
        check("multi_fcnt",  64'(flush_cnt), 64'd2);
        check("multi_data",  out_data, NOP);
        check("multi_scnt",  64'(stall_cnt), 64'd7);

        // Bubble
        flush = 1'b0; in_valid = 1'b0; in_data = 64'h55;
        step();
        check("bub_valid",   64'(out_valid), 64'd0);
        check("bub_data",    out_data, 64'h55);
        check("bub_fcnt",    64'(flush_cnt), 64'd2);
        check("bub_scnt",    64'(stall_cnt), 64'd7);

        // Direct flush, then normal load
        in_valid = 1'b1; in_data = 64'hCAFE; flush = 1'b1;
        step();
        check("dflush_valid", 64'(out_valid), 64'd0);
        check("dflush_data",  out_data, NOP);
        check("dflush_fcnt",  64'(flush_cnt), 64'd3);
        check("dflush_pend",  64'(flush_pending), 64'd0);
        flush = 1'b0;
        step();
        check("after_valid", 64'(out_valid), 64'd1);
        check("after_data",  out_data, 64'hCAFE);
        check("after_fcnt",  64'(flush_cnt), 64'd3);

        // Async reset while PEND
        reset = 1'b1;
        step();
        reset = 1'b0;
        stall = 1'b1;
        repeat (4) step();
        flush = 1'b1;
        step();
        check("pre_pend",    64'(flush_pending), 64'd1);
        check("pre_scnt",    64'(stall_cnt), 64'd5);
        #3;
        reset = 1'b1;
        #1;
        check("arst_pend",   64'(flush_pending), 64'd0);
        check("arst_scnt",   64'(stall_cnt), 64'd0);
        check("arst_valid",  64'(out_valid), 64'd0);
        check("arst_data",   out_data, NOP);
        stall = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'h77;
        #1;
        reset = 1'b0;
        step();
        check("rel_fcnt",    64'(flush_cnt), 64'd0);
        check("rel_valid",   64'(out_valid), 64'd1);
        check("rel_data",    out_data, 64'h77);
        check("rel_pend",    64'(flush_pending), 64'd0);

        // Saturation on the CNT_W=2 stage
        check("sat_start",   64'(s_stall_cnt), 64'd0);
        s_stall = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("sat_%0d", i), 64'(s_stall_cnt), (i < 3) ? 64'(i) : 64'd3);
        end
        s_stall = 1'b0;
        step();
        check("sat_hold",    64'(s_stall_cnt), 64'd3);
        check("sat_fcnt",    64'(s_flush_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
